pipe_adder: RTL and testbench

//  Parametrised, pipelined ripple-carry adder; next generation of the single-bit fulladder.

---
 rtl/adder_pkg.sv | 19 +
 rtl/ripple_chunk.sv | 40 ++++
 rtl/pipe_adder.sv | 114 +++++++++++
 tb/tb_pipe_adder.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared parameters, chunk sizing and per-stage control record for the pipelined adder.
package adder_pkg;

    localparam int DEF_WIDTH  = 16;
    localparam int DEF_STAGES = 4;

    function automatic int chunk_width(input int width, input int stages);
        return width / stages;
    endfunction

    // Control half of a stage record; the partial sum and the still-unused
    // operand chunks live in parallel WIDTH-wide registers in pipe_adder.
    typedef struct packed {
        logic valid;
        logic carry;
        logic ovf;
    } stage_ctl_t;

endpackage

// File: rtl/ripple_chunk.sv
// Single-bit full adder and a combinational CHUNK-bit ripple adder built from a chain of them.
module fulladder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

module ripple_chunk #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout,
    output logic             c_msb
);
    logic [CHUNK:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < CHUNK; i++) begin : gen_fa
        fulladder u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (c[i]),
            .sum  (sum[i]),
            .cout (c[i+1])
        );
    end

    assign cout  = c[CHUNK];
    // Carry into the top bit, needed by the last stage for signed overflow.
    assign c_msb = c[CHUNK-1];
endmodule

// File: rtl/pipe_adder.sv
// Pipelined ripple-carry adder: one CHUNK-bit slice per stage, carry registered between
// stages, streamed under valid/ready with a single global advance enable.
module pipe_adder
    import adder_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int STAGES = DEF_STAGES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);
    localparam int CHUNK = chunk_width(WIDTH, STAGES);

    if (STAGES < 1 || (WIDTH % STAGES) != 0) begin : gen_bad_cfg
        $error("pipe_adder: STAGES must be >= 1 and divide WIDTH");
    end

    logic adv;

    stage_ctl_t       ctl_q [STAGES];
    stage_ctl_t       ctl_d [STAGES];
    logic [WIDTH-1:0] sum_q [STAGES];
    logic [WIDTH-1:0] sum_d [STAGES];
    logic [WIDTH-1:0] a_q   [STAGES];
    logic [WIDTH-1:0] a_d   [STAGES];
    logic [WIDTH-1:0] b_q   [STAGES];
    logic [WIDTH-1:0] b_d   [STAGES];

    logic [WIDTH-1:0] a_in   [STAGES];
    logic [WIDTH-1:0] b_in   [STAGES];
    logic [WIDTH-1:0] sum_in [STAGES];
    logic             c_in   [STAGES];
    logic             v_in   [STAGES];

    logic [CHUNK-1:0] chunk_sum  [STAGES];
    logic             chunk_cout [STAGES];
    logic             chunk_cmsb [STAGES];

    assign adv      = !ctl_q[STAGES-1].valid || out_ready;
    assign in_ready = adv && !rst;

    always_comb begin
        a_in[0]   = a;
        b_in[0]   = b;
        sum_in[0] = '0;
        c_in[0]   = cin;
        v_in[0]   = in_valid;
        for (int k = 1; k < STAGES; k++) begin
            a_in[k]   = a_q[k-1];
            b_in[k]   = b_q[k-1];
            sum_in[k] = sum_q[k-1];
            c_in[k]   = ctl_q[k-1].carry;
            v_in[k]   = ctl_q[k-1].valid;
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : gen_stage
        ripple_chunk #(.CHUNK(CHUNK)) u_chunk (
            .a     (a_in[k][k*CHUNK +: CHUNK]),
            .b     (b_in[k][k*CHUNK +: CHUNK]),
            .cin   (c_in[k]),
            .sum   (chunk_sum[k]),
            .cout  (chunk_cout[k]),
            .c_msb (chunk_cmsb[k])
        );
    end

    // Operands skew forward unchanged; each stage splices its slice into the running sum.
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            ctl_d[k].valid               = v_in[k];
            ctl_d[k].carry               = chunk_cout[k];
            ctl_d[k].ovf                 = chunk_cmsb[k] ^ chunk_cout[k];
            sum_d[k]                     = sum_in[k];
            sum_d[k][k*CHUNK +: CHUNK]   = chunk_sum[k];
            a_d[k]                       = a_in[k];
            b_d[k]                       = b_in[k];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                ctl_q[k] <= '0;
                sum_q[k] <= '0;
                a_q[k]   <= '0;
                b_q[k]   <= '0;
            end
        end else if (adv) begin
            for (int k = 0; k < STAGES; k++) begin
                ctl_q[k] <= ctl_d[k];
                sum_q[k] <= sum_d[k];
                a_q[k]   <= a_d[k];
                b_q[k]   <= b_d[k];
            end
        end
    end

    assign out_valid = ctl_q[STAGES-1].valid;
    assign sum       = sum_q[STAGES-1];
    assign cout      = ctl_q[STAGES-1].carry;
    assign overflow  = ctl_q[STAGES-1].ovf;

endmodule

// File: tb/tb_pipe_adder.sv
// Self-checking bench for pipe_adder: directed corner cases plus a random stream with
// output stalls, scored against an arithmetic reference model.
module tb_pipe_adder;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, cin, out_valid, out_ready, cout, overflow;
    logic [15:0] a, b, sum;

    logic        in_valid_8, in_ready_8, cin_8, out_valid_8, out_ready_8, cout_8, overflow_8;
    logic [7:0]  a_8, b_8, sum_8;

    int          errors = 0;
    int          checks = 0;
    int          cyc    = 0;
    int          n_pop  = 0;
    logic [31:0] exp_q[$];
    int          iss_q[$];
    bit          lat_on       = 1'b0;
    bit          hold_pending = 1'b0;
    logic [31:0] held;
    logic [31:0] last_out;
    logic        last_in_ready;
    logic        last_ov;

    always #5 clk = ~clk;

    pipe_adder #(.WIDTH(16), .STAGES(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .overflow(overflow)
    );

    pipe_adder #(.WIDTH(8), .STAGES(1)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid_8), .in_ready(in_ready_8),
        .a(a_8), .b(b_8), .cin(cin_8), .out_valid(out_valid_8), .out_ready(out_ready_8),
        .sum(sum_8), .cout(cout_8), .overflow(overflow_8)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Returns {ovf, cout, sum} for a w-bit add, from plain integer arithmetic.
    function automatic logic [31:0] ref_add(input int w, input longint x, input longint y,
                                            input longint c);
        longint full, half, sx, sy, ss, res;
        half = longint'(1) << (w - 1);
        full = x + y + c;
        sx   = (x >= half) ? x - 2 * half : x;
        sy   = (y >= half) ? y - 2 * half : y;
        ss   = sx + sy + c;
        res  = full % (2 * half);
        if (full >= 2 * half) res = res + (longint'(1) << w);
        if (ss < -half || ss >= half) res = res + (longint'(1) << (w + 1));
        return 32'(res);
    endfunction

    // One cycle on the 16-bit DUT: drive, sample mid-cycle, score, advance to next negedge.
    task automatic cycle(input logic v, input logic [15:0] ai, input logic [15:0] bi,
                         input logic ci, input logic ordy);
        logic [31:0] obs;
        int          lat;
        in_valid  = v;
        a         = ai;
        b         = bi;
        cin       = ci;
        out_ready = ordy;
        #1;
        obs           = {14'd0, overflow, cout, sum};
        last_in_ready = in_ready;
        last_ov       = out_valid;
        if (hold_pending) begin
            check("stall_valid", 32'(out_valid), 32'd1);
            check("stall_hold", obs, held);
        end
        hold_pending = out_valid && !out_ready;
        held         = obs;
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("spurious_out", 32'(out_valid), 32'd0);
            end else begin
                check("result", obs, exp_q.pop_front());
                lat = cyc - iss_q.pop_front();
                if (lat_on) check("latency", 32'(lat), 32'd4);
                last_out = obs;
                n_pop++;
            end
        end
        if (in_valid && in_ready) begin
            exp_q.push_back(ref_add(16, longint'(ai), longint'(bi), longint'(ci)));
            iss_q.push_back(cyc);
        end
        cyc++;
        @(negedge clk);
    endtask

    initial begin
        int          p0;
        logic [31:0] prev8, pend8;

        rst = 1'b1;
        in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b0;
        in_valid_8 = 1'b0; a_8 = '0; b_8 = '0; cin_8 = 1'b0; out_ready_8 = 1'b0;
        repeat (2) @(negedge clk);

        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_outputs", {14'd0, overflow, cout, sum}, 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst8_out_valid", 32'(out_valid_8), 32'd0);
        check("rst8_in_ready", 32'(in_ready_8), 32'd0);

        rst = 1'b0;
        #1;
        check("in_ready_after_rst", 32'(in_ready), 32'd1);
        @(negedge clk);

        // Directed wrap/overflow corners with exact latency.
        lat_on = 1'b1;
        cycle(1'b1, 16'hFFFF, 16'h0001, 1'b0, 1'b1);
        repeat (5) cycle(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
        check("t1_value", last_out, 32'h0001_0000);
        cycle(1'b1, 16'h7FFF, 16'h0001, 1'b0, 1'b1);
        repeat (5) cycle(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
        check("t2_pos_ovf", last_out, 32'h0002_8000);
        cycle(1'b1, 16'h8000, 16'h8000, 1'b0, 1'b1);
        repeat (5) cycle(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
        check("t2_neg_ovf", last_out, 32'h0003_0000);

        // Back-to-back stream: fixed latency for every op means consecutive outputs.
        p0 = n_pop;
        for (int i = 0; i < 8; i++) begin
            logic [31:0] iv;
            iv = 32'(i);
            cycle(1'b1, iv[15:0], 16'(32'h1000 * iv), iv[0], 1'b1);
        end
        repeat (5) cycle(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
        check("t3_count", 32'(n_pop - p0), 32'd8);
        lat_on = 1'b0;

        // Fill with the output blocked, stall three cycles, then drain.
        p0 = n_pop;
        repeat (4) cycle(1'b1, 16'($urandom), 16'($urandom), 1'($urandom), 1'b0);
        repeat (3) begin
            cycle(1'b1, 16'($urandom), 16'($urandom), 1'($urandom), 1'b0);
            check("t4_in_ready", 32'(last_in_ready), 32'd0);
        end
        repeat (6) cycle(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
        check("t4_count", 32'(n_pop - p0), 32'd4);

        // Reset with three ops in flight: none of them may surface.
        repeat (3) cycle(1'b1, 16'($urandom), 16'($urandom), 1'($urandom), 1'b1);
        rst      = 1'b1;
        in_valid = 1'b1;
        #1;
        check("t5_in_ready_rst", 32'(in_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        iss_q.delete();
        hold_pending = 1'b0;
        repeat (6) begin
            cycle(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
            check("t5_out_valid", 32'(last_ov), 32'd0);
        end

        // Random stream with random output backpressure.
        for (int i = 0; i < 400; i++) begin
            cycle(1'(($urandom % 4) != 0), 16'($urandom), 16'($urandom), 1'($urandom),
                  1'(($urandom % 3) != 0));
        end
        repeat (10) cycle(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
        check("drain_empty", 32'(exp_q.size()), 32'd0);

        // Single-stage 8-bit instance: one cycle latency, first op is the fixed corner.
        prev8 = '0;
        for (int i = 0; i < 12; i++) begin
            a_8         = (i == 0) ? 8'hAA : 8'($urandom);
            b_8         = (i == 0) ? 8'h55 : 8'($urandom);
            cin_8       = (i == 0) ? 1'b1  : 1'($urandom);
            in_valid_8  = 1'b1;
            out_ready_8 = 1'b1;
            #1;
            check("d8_in_ready", 32'(in_ready_8), 32'd1);
            pend8 = ref_add(8, longint'(a_8), longint'(b_8), longint'(cin_8));
            if (i > 0) begin
                check("d8_valid", 32'(out_valid_8), 32'd1);
                check("d8_result", {22'd0, overflow_8, cout_8, sum_8}, prev8);
            end
            if (i == 1) check("t6_value", {21'd0, out_valid_8, overflow_8, cout_8, sum_8},
                              32'h0000_0500);
            prev8 = pend8;
            @(negedge clk);
        end
        in_valid_8 = 1'b0;
        #1;
        check("d8_last", {22'd0, overflow_8, cout_8, sum_8}, prev8);
        @(negedge clk);
        #1;
        check("d8_idle", 32'(out_valid_8), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
